// File: rtl/step_clock_gen_if.sv
// Bundles the step-clock generator's button/mode inputs and CPU-facing outputs.
// The master side drives the controls; the slave side is the generator.
interface step_clock_gen_if #(
    parameter int CNT_W = 32
) ();
    logic             btn;
    logic             run_mode;
    logic             halt_req;
    logic             step_pulse;
    logic             btn_level;
    logic [1:0]       mode_state;
    logic [CNT_W-1:0] step_count;

    modport master (
        output btn,
        output run_mode,
        output halt_req,
        input  step_pulse,
        input  btn_level,
        input  mode_state,
        input  step_count
    );

    modport slave (
        input  btn,
        input  run_mode,
        input  halt_req,
        output step_pulse,
        output btn_level,
        output mode_state,
        output step_count
    );
endinterface

// File: rtl/step_clock_gen.sv
// CPU step-clock source: synchronized, debounced step button driving single
// steps, or a free-running divided strobe with press-to-pause.
module step_clock_gen #(
    parameter int DB_LIMIT = 1000000,
    parameter int RUN_DIV  = 50000000,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    step_clock_gen_if.slave bus
);
    localparam int DB_W  = $clog2(DB_LIMIT);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_LIMIT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_STEP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } mode_e;

    logic [1:0] async_in;
    logic [1:0] sync_vec;
    logic       sync_btn;
    logic       sync_run;

    assign async_in = {bus.run_mode, bus.btn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic s1_d, s1_q, s2_d, s2_q;

        always_comb begin
            s1_d = async_in[gi];
            s2_d = s1_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
        end

        assign sync_vec[gi] = s2_q;
    end

    assign sync_btn = sync_vec[0];
    assign sync_run = sync_vec[1];

    logic [DB_W-1:0]  db_cnt_d, db_cnt_q;
    logic             btn_level_d, btn_level_q;
    logic             btn_prev_d, btn_prev_q;
    logic             press;
    mode_e            state_d, state_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic             pulse_raw;
    logic             step_pulse_d, step_pulse_q;
    logic [CNT_W-1:0] step_count_d, step_count_q;

    // The level only moves after DB_LIMIT consecutive disagreeing samples.
    always_comb begin
        db_cnt_d    = '0;
        btn_level_d = btn_level_q;
        if (sync_btn != btn_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_level_d = sync_btn;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        btn_prev_d = btn_level_q;
    end

    assign press = btn_level_q & ~btn_prev_q;

    // Mode-switch checks come first so a coincident press is discarded.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pulse_raw = 1'b0;
        case (state_q)
            ST_STEP: begin
                div_d = '0;
                if (sync_run) begin
                    state_d = ST_RUN;
                end else if (press) begin
                    pulse_raw = 1'b1;
                end
            end
            ST_RUN: begin
                if (!sync_run) begin
                    state_d = ST_STEP;
                    div_d   = '0;
                end else if (press) begin
                    state_d = ST_PAUSE;
                end else if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    pulse_raw = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PAUSE: begin
                if (!sync_run) begin
                    state_d = ST_STEP;
                    div_d   = '0;
                end else if (press) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_STEP;
                div_d   = '0;
            end
        endcase
        // Halt drops the strobe but leaves the divider phase untouched.
        step_pulse_d = pulse_raw & ~bus.halt_req;
        step_count_d = step_count_q + CNT_W'(step_pulse_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q     <= '0;
            btn_level_q  <= 1'b0;
            btn_prev_q   <= 1'b0;
            state_q      <= ST_STEP;
            div_q        <= '0;
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            db_cnt_q     <= db_cnt_d;
            btn_level_q  <= btn_level_d;
            btn_prev_q   <= btn_prev_d;
            state_q      <= state_d;
            div_q        <= div_d;
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.btn_level  = btn_level_q;
    assign bus.mode_state = state_q;
    assign bus.step_count = step_count_q;
endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen: expected pulses (cycle, count) are
// queued when stimulus is applied and matched as the DUT strobes step_pulse.
module tb_step_clock_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_item;

    step_clock_gen_if #(.CNT_W(32)) bus ();

    step_clock_gen #(
        .DB_LIMIT(4),
        .RUN_DIV (5),
        .CNT_W   (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end else begin
            $display("[TB] ok   %s @cyc %0d: %0d", tag, cyc, act);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        sb_q.push_back(e);
    endtask

    // Every observed strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.step_pulse === 1'b1) begin
            check_eq("sb_has_entry", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_item = sb_q.pop_front();
                check_eq("pulse_cycle", cyc, sb_item.cyc);
                check_eq("pulse_count", bus.step_count, sb_item.cnt);
            end
        end
    end

    initial begin
        bus.btn      = 1'b0;
        bus.run_mode = 1'b0;
        bus.halt_req = 1'b0;

        // Reset for edges 1..3.
        goto(3);
        check_eq("rst_pulse", bus.step_pulse, 0);
        check_eq("rst_level", bus.btn_level, 0);
        check_eq("rst_mode",  bus.mode_state, 0);
        check_eq("rst_count", bus.step_count, 0);
        rst = 1'b0;

        // Clean press in STEP mode.
        goto(10);
        bus.btn = 1'b1;
        push_exp(17, 1);
        goto(15);
        check_eq("press_level_pre", bus.btn_level, 0);
        goto(16);
        check_eq("press_level", bus.btn_level, 1);
        goto(60);
        bus.btn = 1'b0;
        goto(66);
        check_eq("release_level", bus.btn_level, 0);
        check_eq("hold_count", bus.step_count, 1);

        // Bounce shorter than the debounce window.
        for (int c = 70; c <= 100; c++) begin
            goto(c);
            if (c < 90 && (c % 2) == 0) bus.btn = ((c - 70) % 4 == 0);
            check_eq("bounce_level", bus.btn_level, 0);
        end
        check_eq("bounce_count", bus.step_count, 1);

        // RUN mode: entry three edges after the switch, then period 5.
        goto(110);
        bus.run_mode = 1'b1;
        push_exp(118, 2);
        push_exp(123, 3);
        push_exp(128, 4);
        push_exp(133, 5);
        goto(112);
        check_eq("run_mode_pre", bus.mode_state, 0);
        goto(113);
        check_eq("run_mode", bus.mode_state, 1);

        // Press while running: pause with the divider held at 3.
        goto(135);
        check_eq("run_count", bus.step_count, 5);
        bus.btn = 1'b1;
        push_exp(138, 6);
        goto(141);
        check_eq("pause_mode_pre", bus.mode_state, 1);
        goto(142);
        check_eq("pause_mode", bus.mode_state, 2);
        goto(150);
        bus.btn = 1'b0;
        goto(171);
        check_eq("pause_mode_hold", bus.mode_state, 2);
        check_eq("pause_count", bus.step_count, 6);

        // Resume: first pulse RUN_DIV - 3 = 2 cycles after re-entry.
        goto(172);
        bus.btn = 1'b1;
        push_exp(181, 7);
        push_exp(186, 8);
        push_exp(191, 9);
        push_exp(196, 10);
        goto(178);
        check_eq("resume_mode_pre", bus.mode_state, 2);
        goto(179);
        check_eq("resume_mode", bus.mode_state, 1);
        goto(190);
        bus.btn = 1'b0;

        // Halt for 12 cycles: terminal counts at 201 and 206 are dropped.
        goto(197);
        bus.halt_req = 1'b1;
        push_exp(211, 11);
        push_exp(216, 12);
        goto(209);
        bus.halt_req = 1'b0;
        goto(210);
        check_eq("halt_count", bus.step_count, 10);

        // Pause again, then reset with a new press mid-debounce.
        goto(217);
        bus.btn = 1'b1;
        push_exp(221, 13);
        goto(224);
        check_eq("pause2_mode", bus.mode_state, 2);
        goto(230);
        bus.btn = 1'b0;
        goto(240);
        bus.btn = 1'b1;
        goto(243);
        rst = 1'b1;
        bus.run_mode = 1'b0;
        goto(244);
        check_eq("mid_rst_mode",  bus.mode_state, 0);
        check_eq("mid_rst_count", bus.step_count, 0);
        check_eq("mid_rst_level", bus.btn_level, 0);
        goto(245);
        rst = 1'b0;
        push_exp(252, 1);
        goto(250);
        check_eq("post_rst_level_pre", bus.btn_level, 0);
        goto(251);
        check_eq("post_rst_level", bus.btn_level, 1);
        goto(255);
        check_eq("post_rst_count", bus.step_count, 1);
        check_eq("post_rst_mode", bus.mode_state, 0);

        goto(260);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
